vga_fb_line_fetch: RTL and testbench

//  Pixel source directly upstream of the 1280x1024 VGA timing driver. Consumes its h_addr/v_addr and

---
 rtl/vga_fb_line_fetch.sv | 205 ++++++++++++++++++++
 tb/tb_vga_fb_line_fetch.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_line_fetch.sv
// vga_fb_line_fetch: ping-pong line buffer pixel source for a 1280x1024 VGA driver.
// A 320x256 12-bit framebuffer in external memory is scaled 4x in both axes. One
// bank shows the current source row while the other prefetches the next one over
// a single-outstanding req/ack read port.
module vga_fb_line_fetch #(
    parameter int          SRC_W    = 320,
    parameter int          SRC_H    = 256,
    parameter int          SCALE_SH = 2,
    parameter int          DATA_W   = 12,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic [10:0]       h_addr,
    input  logic [10:0]       v_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              mem_req,
    output logic [16:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              underrun
);

    localparam int ROW_W  = $clog2(SRC_H);
    localparam int COL_W  = $clog2(SRC_W);
    localparam int ADDR_W = 17;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SRC_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    state_t state, next_state;

    // Fill bookkeeping, latched when a fetch is launched from IDLE
    logic             fill_bank;
    logic [ROW_W-1:0] fill_row;
    logic [COL_W-1:0] col;

    // Per-bank residency: valid bit plus the source row held
    logic [1:0]       valid;
    logic [ROW_W-1:0] tag0;
    logic [ROW_W-1:0] tag1;

    // Line storage; contents are deliberately not reset
    logic [DATA_W-1:0] line_buf0 [0:SRC_W-1];
    logic [DATA_W-1:0] line_buf1 [0:SRC_W-1];

    // Scan position in source coordinates
    logic [ROW_W-1:0] s_row;
    logic [ROW_W-1:0] n_row;
    logic [COL_W-1:0] c_col;

    // Residency lookups and fetch selection
    logic             hit0_s, hit1_s, hit0_n, hit1_n;
    logic             disp_hit;
    logic             disp_bank;
    logic             need_fetch;
    logic             sel_bank;
    logic [ROW_W-1:0] sel_row;

    // First memory word of a source row
    function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
        return ADDR_W'(row) * ADDR_W'(SRC_W);
    endfunction

    // Map the driver position to source row/column and the prefetch row (wraps at frame end)
    always_comb begin
        s_row = ROW_W'(v_addr >> SCALE_SH);
        c_col = COL_W'(h_addr >> SCALE_SH);
        n_row = (s_row == ROW_LAST) ? '0 : s_row + ROW_W'(1);
    end

    // Decide which bank is displayed and what, if anything, IDLE should fetch next
    always_comb begin
        hit0_s     = valid[0] && (tag0 == s_row);
        hit1_s     = valid[1] && (tag1 == s_row);
        hit0_n     = valid[0] && (tag0 == n_row);
        hit1_n     = valid[1] && (tag1 == n_row);
        disp_hit   = hit0_s || hit1_s;
        disp_bank  = !hit0_s;
        need_fetch = 1'b0;
        sel_bank   = 1'b0;
        sel_row    = s_row;
        if (!disp_hit) begin
            // Displayed row missing: refill it, sparing a bank that already holds the next row
            need_fetch = 1'b1;
            sel_bank   = hit0_n;
            sel_row    = s_row;
        end else if (!(hit0_n || hit1_n)) begin
            // Prefetch into the bank not on screen so the visible line is never torn
            need_fetch = 1'b1;
            sel_bank   = !disp_bank;
            sel_row    = n_row;
        end
    end

    // Pixel output straight from the displayed bank, background when nothing matches
    always_comb begin
        vga_data = BG_COLOR;
        if (disp_hit) begin
            vga_data = disp_bank ? line_buf1[c_col] : line_buf0[c_col];
        end
    end

    // FSM state register
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state; a fetch runs to completion once started
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (need_fetch) begin
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (mem_ack && (col == COL_LAST)) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Fetch datapath: launch, address/column stepping per ack, and bank commit
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            fill_bank <= 1'b0;
            fill_row  <= '0;
            col       <= '0;
            mem_addr  <= '0;
            valid     <= 2'b00;
            tag0      <= '0;
            tag1      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (need_fetch) begin
                        fill_bank        <= sel_bank;
                        fill_row         <= sel_row;
                        valid[sel_bank]  <= 1'b0;
                        col              <= '0;
                        mem_addr         <= row_base(sel_row);
                    end
                end
                ST_REQ: begin
                    if (mem_ack && (col != COL_LAST)) begin
                        col      <= col + COL_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    valid[fill_bank] <= 1'b1;
                    if (fill_bank) begin
                        tag1 <= fill_row;
                    end else begin
                        tag0 <= fill_row;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Line RAM write port: one pixel per accepted read
    always_ff @(posedge pclk) begin
        if (mem_req && mem_ack) begin
            if (fill_bank) begin
                line_buf1[col] <= mem_rdata;
            end else begin
                line_buf0[col] <= mem_rdata;
            end
        end
    end

    // Sticky underrun flag; the origin position doubles as blanking and is excused
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
        end else if (!disp_hit && ((v_addr != '0) || (h_addr != '0))) begin
            underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_fb_line_fetch.sv
// Directed bench for vga_fb_line_fetch with a latency-programmable memory model
// whose read data is the low 12 bits of the requested address.
module tb_vga_fb_line_fetch;

    logic        pclk = 1'b0;
    logic        reset_n = 1'b1;
    logic [10:0] h_addr = '0;
    logic [10:0] v_addr = '0;
    logic [11:0] vga_data;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_ack;
    logic [11:0] mem_rdata;
    logic        underrun;

    int checks = 0;
    int failures = 0;

    // Memory model controls
    logic mem_en = 1'b1;
    int   lat = 0;
    int   wait_cnt = 0;

    // Fetch monitor
    logic clr_mon = 1'b0;
    logic req_q = 1'b0;
    int   acks = 0;
    int   starts[$];
    int   acks_at[$];

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[11];

    vga_fb_line_fetch dut (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .h_addr    (h_addr),
        .v_addr    (v_addr),
        .vga_data  (vga_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .underrun  (underrun)
    );

    always #5 pclk = ~pclk;

    always_comb begin
        mem_ack   = mem_en && mem_req && (wait_cnt >= lat);
        mem_rdata = mem_addr[11:0];
    end

    always @(posedge pclk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(negedge pclk) begin
        if (clr_mon) begin
            acks  <= 0;
            req_q <= 1'b0;
            starts.delete();
            acks_at.delete();
        end else begin
            if (mem_req && mem_ack) acks <= acks + 1;
            if (mem_req && !req_q) begin
                starts.push_back(int'(mem_addr));
                acks_at.push_back(acks);
            end
            req_q <= mem_req;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset(input logic en, input int l);
        mem_en  = en;
        lat     = l;
        clr_mon = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        reset_n = 1'b1;
        clr_mon = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int  lows;
        logic ok;
        lows = 0;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!mem_req) lows++;
            else lows = 0;
            if (lows >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_addr(input string name, input logic [16:0] target, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (mem_req && mem_addr == target) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    function automatic int q_at(input int idx);
        if (idx >= 0 && idx < starts.size()) return starts[idx];
        return -1;
    endfunction

    function automatic int a_at(input int idx);
        if (idx >= 0 && idx < acks_at.size()) return acks_at[idx];
        return -1;
    endfunction

    initial begin
        logic saw_pf;
        logic bg_seen;
        logic hold_ok;
        logic got;

        // Expected pixel = (s*320 + (h>>2))[11:0]
        tbl[0]  = '{11'd4,    11'd0, 12'h001};
        tbl[1]  = '{11'd8,    11'd0, 12'h002};
        tbl[2]  = '{11'd11,   11'd3, 12'h002};
        tbl[3]  = '{11'd12,   11'd2, 12'h003};
        tbl[4]  = '{11'd1279, 11'd1, 12'h13F};
        tbl[5]  = '{11'd640,  11'd3, 12'h0A0};
        tbl[6]  = '{11'd1023, 11'd1, 12'h0FF};
        tbl[7]  = '{11'd0,    11'd4, 12'h140};
        tbl[8]  = '{11'd8,    11'd5, 12'h142};
        tbl[9]  = '{11'd1279, 11'd7, 12'h27F};
        tbl[10] = '{11'd400,  11'd6, 12'h1A4};

        // 1) Reset state, zero-wait fill of rows 0 then 1, table of pixel lookups
        h_addr = 11'd8;
        v_addr = 11'd0;
        #2;
        do_reset(1'b1, 0);
        chk("t1_rst_req", 32'(mem_req), 32'd0);
        chk("t1_rst_addr", 32'(mem_addr), 32'd0);
        chk("t1_rst_bg", 32'(vga_data), 32'h000);
        chk("t1_rst_underrun", 32'(underrun), 32'd0);
        h_addr = 11'd0;
        wait_idle("t1_idle", 1000);
        chk("t1_nfetch", 32'(starts.size()), 32'd2);
        chk("t1_first_row", 32'(q_at(0)), 32'd0);
        chk("t1_second_row", 32'(q_at(1)), 32'd320);
        for (int i = 0; i < 11; i++) begin
            h_addr = tbl[i].h;
            v_addr = tbl[i].v;
            #2;
            chk($sformatf("t1_vec%0d", i), 32'(vga_data), 32'(tbl[i].exp));
            step();
        end
        chk("t1_underrun", 32'(underrun), 32'd0);

        // 2) Ack delayed 3 cycles, seamless switch row 0 -> row 1, prefetch of row 2
        h_addr = 11'd0;
        v_addr = 11'd0;
        do_reset(1'b1, 3);
        wait_idle("t2_idle", 4000);
        h_addr = 11'd8;
        v_addr = 11'd3;
        #1;
        chk("t2_row0", 32'(vga_data), 32'h002);
        v_addr = 11'd4;
        #1;
        chk("t2_switch", 32'(vga_data), 32'h142);
        saw_pf = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (mem_req && mem_addr == 17'd640) saw_pf = 1'b1;
        end
        chk("t2_prefetch", 32'(saw_pf), 32'd1);
        bg_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (vga_data != 12'h142) bg_seen = 1'b1;
        end
        chk("t2_no_bg", 32'(bg_seen), 32'd0);
        chk("t2_underrun", 32'(underrun), 32'd0);

        // 3) Last source row and wrap to row 0 before the new frame
        h_addr = 11'd8;
        v_addr = 11'd1023;
        step();
        chk("t3_urgent_bg", 32'(vga_data), 32'h000);
        wait_idle("t3_idle", 6000);
        chk("t3_row255", 32'(vga_data), 32'hEC2);
        chk("t3_fetch255", 32'(q_at(starts.size() - 2)), 32'd81600);
        chk("t3_fetch0", 32'(q_at(starts.size() - 1)), 32'd0);
        h_addr = 11'd4;
        v_addr = 11'd0;
        #1;
        chk("t3_wrap_first", 32'(vga_data), 32'h001);
        h_addr = 11'd1276;
        #1;
        chk("t3_wrap_last", 32'(vga_data), 32'h13F);

        // 4) Memory stalled from reset
        h_addr = 11'd0;
        v_addr = 11'd0;
        do_reset(1'b0, 0);
        step();
        step();
        h_addr = 11'd8;
        v_addr = 11'd4;
        hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!(mem_req && mem_addr == 17'd0)) hold_ok = 1'b0;
        end
        chk("t4_req_hold", 32'(hold_ok), 32'd1);
        chk("t4_bg", 32'(vga_data), 32'h000);
        chk("t4_underrun", 32'(underrun), 32'd1);

        // 5) Reset asserted in the middle of a prefetch
        h_addr = 11'd0;
        v_addr = 11'd0;
        do_reset(1'b1, 0);
        wait_idle("t5_idle", 1000);
        h_addr = 11'd8;
        v_addr = 11'd4;
        #1;
        chk("t5_row1", 32'(vga_data), 32'h142);
        wait_addr("t5_reach150", 17'd790, 400);
        reset_n = 1'b0;
        #1;
        chk("t5_req_drop", 32'(mem_req), 32'd0);
        chk("t5_addr_clr", 32'(mem_addr), 32'd0);
        chk("t5_valid_clr", 32'(vga_data), 32'h000);
        repeat (2) @(posedge pclk);
        #1;
        reset_n = 1'b1;
        step();
        chk("t5_restart_req", 32'(mem_req), 32'd1);
        chk("t5_restart_addr", 32'(mem_addr), 32'd320);

        // 6) Row jump 25 -> 150 during a fetch
        h_addr = 11'd8;
        v_addr = 11'd100;
        do_reset(1'b1, 0);
        wait_addr("t6_reach", 17'd8100, 400);
        v_addr = 11'd600;
        step();
        chk("t6_bg", 32'(vga_data), 32'h000);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (starts.size() >= 2) begin
                got = 1'b1;
                break;
            end
        end
        chk("t6_second_fetch", 32'(got), 32'd1);
        chk("t6_first_row", 32'(q_at(0)), 32'd8000);
        chk("t6_urgent_row", 32'(q_at(1)), 32'd48000);
        chk("t6_completed", 32'(a_at(1)), 32'd320);
        chk("t6_fill_bg", 32'(vga_data), 32'h000);
        wait_idle("t6_idle", 2000);
        chk("t6_nfetch", 32'(starts.size()), 32'd3);
        chk("t6_prefetch_row", 32'(q_at(2)), 32'd48320);
        chk("t6_pixel", 32'(vga_data), 32'hB82);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
